serial_adder_n: RTL and testbench

Bit-serial N-bit adder built around the team's 1-bit full adder cell (`full_adder_1`, one instance, reused every cycle). It latches two operands and a carry-in on a start pulse, then adds one bit per clock, LSB first, with a registered carry. It presents the full sum, carry-out and completion flag after WIDTH cycles. It is the first multi-bit stage consuming the full-adder cell and feeds later accumulator/ALU blocks.

---
 rtl/serial_adder_n.sv | 186 ++++++++++++++++++
 tb/tb_serial_adder_n.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_n.sv
// -----------------------------------------------------------------------------
// serial_adder_n
//
// Bit-serial N-bit adder. One 1-bit full adder cell (full_adder_1) is reused
// every clock. Two operands and a carry-in are latched on an accepted start.
// The block then adds one bit per cycle, LSB first, with a registered carry.
// After WIDTH cycles it presents the full sum, the carry-out and a one-cycle
// done pulse.
//
// Optional feature macro: SERIAL_ADDER_N_OVF_EN
//   When this macro is defined, the o_ovf port exists and reports two's-
//   complement overflow of A+B+cin. When it is undefined, the port and its
//   logic are absent.
//
// Ports
//   i_clk    in   1      clock, rising edge
//   i_rst_n  in   1      asynchronous active-low reset
//   i_start  in   1      start request (accepted in IDLE or DONE)
//   i_a      in   WIDTH  operand A, latched on accept
//   i_b      in   WIDTH  operand B, latched on accept
//   i_cin    in   1      carry-in, latched on accept
//   o_busy   out  1      high while bits are being processed
//   o_done   out  1      one-cycle pulse, result valid
//   o_sum    out  WIDTH  registered sum, held until the next completion
//   o_cout   out  1      registered carry-out of bit WIDTH-1
//   o_ovf    out  1      registered signed overflow (macro builds only)
// -----------------------------------------------------------------------------

// 1-bit full adder cell.
//   i_a, i_b, i_cin : addend bits and carry-in
//   o_sum, o_cout   : sum bit and carry-out
module full_adder_1 (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

module serial_adder_n #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
`ifdef SERIAL_ADDER_N_OVF_EN
    output logic             o_cout,
    output logic             o_ovf
`else
    output logic             o_cout
`endif
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] s_sr_q, s_sr_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
`ifdef SERIAL_ADDER_N_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic fa_sum;
    logic fa_cout;

    // The single shared cell always works on the current LSBs and the carry.
    full_adder_1 u_fa (
        .i_a    (a_sr_q[0]),
        .i_b    (b_sr_q[0]),
        .i_cin  (c_q),
        .o_sum  (fa_sum),
        .o_cout (fa_cout)
    );

    // Next-state logic. Every register holds by default. Accepting a start is
    // the same action from IDLE and from DONE, which allows back-to-back runs.
    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        s_sr_d  = s_sr_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDER_N_OVF_EN
        ovf_d   = ovf_q;
`endif

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    a_sr_d  = i_a;
                    b_sr_d  = i_b;
                    c_d     = i_cin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_RUN: begin
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                s_sr_d = {fa_sum, s_sr_q[WIDTH-1:1]};
                c_d    = fa_cout;
                cnt_d  = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    // The result includes the bit that is being computed now.
                    sum_d   = {fa_sum, s_sr_q[WIDTH-1:1]};
                    cout_d  = fa_cout;
`ifdef SERIAL_ADDER_N_OVF_EN
                    // c_q is the carry into the MSB. fa_cout is the carry out of the MSB.
                    ovf_d   = c_q ^ fa_cout;
`endif
                    state_d = ST_DONE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers. Asynchronous reset clears everything.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            s_sr_q  <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_N_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            s_sr_q  <= s_sr_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADDER_N_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign o_busy = (state_q == ST_RUN);
    assign o_done = (state_q == ST_DONE);
    assign o_sum  = sum_q;
    assign o_cout = cout_q;
`ifdef SERIAL_ADDER_N_OVF_EN
    assign o_ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_n.sv
// -----------------------------------------------------------------------------
// tb_serial_adder_n
//
// Self-checking bench for serial_adder_n with WIDTH=8. The reference model
// computes sum, carry and signed overflow with plain integer arithmetic.
// The bench also tracks the held result, so it can check that o_sum does not
// move during a run. The o_ovf checks exist only in builds that define
// SERIAL_ADDER_N_OVF_EN.
// -----------------------------------------------------------------------------
module tb_serial_adder_n;

    localparam int WIDTH = 8;

    logic             i_clk;
    logic             i_rst_n;
    logic             i_start;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_cin;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_sum;
    logic             o_cout;
`ifdef SERIAL_ADDER_N_OVF_EN
    logic             o_ovf;
`endif

    int checkCount = 0;
    int errorCount = 0;

    // Last completed result. After reset it is zero.
    logic [WIDTH-1:0] heldSum  = '0;
    logic             heldCout = 1'b0;
    logic             heldOvf  = 1'b0;

    serial_adder_n #(.WIDTH(WIDTH)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (i_start),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_cin   (i_cin),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_sum   (o_sum),
`ifdef SERIAL_ADDER_N_OVF_EN
        .o_cout  (o_cout),
        .o_ovf   (o_ovf)
`else
        .o_cout  (o_cout)
`endif
    );

    // Free-running 10 ns clock.
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Single comparison point. It counts the check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference arithmetic: unsigned sum and carry, and signed range overflow.
    task automatic modelAdd(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin,
                            output logic [WIDTH-1:0] sum, output logic cout, output logic ovf);
        int ua, ub, sa, sb, total, stotal;
        ua = int'(a);
        ub = int'(b);
        total = ua + ub + int'(cin);
        sum  = WIDTH'(total % (1 << WIDTH));
        cout = (total >= (1 << WIDTH));
        sa = (ua >= (1 << (WIDTH - 1))) ? ua - (1 << WIDTH) : ua;
        sb = (ub >= (1 << (WIDTH - 1))) ? ub - (1 << WIDTH) : ub;
        stotal = sa + sb + int'(cin);
        ovf = (stotal > (1 << (WIDTH - 1)) - 1) || (stotal < -(1 << (WIDTH - 1)));
    endtask

    // Called at a falling edge in IDLE or DONE. It presents operands with
    // start, lets the next rising edge accept them, and then scrambles the
    // operand inputs.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin);
        i_start = 1'b1;
        i_a     = a;
        i_b     = b;
        i_cin   = cin;
        @(negedge i_clk);
        i_start = 1'b0;
        i_a     = WIDTH'($urandom);
        i_b     = WIDTH'($urandom);
        i_cin   = 1'($urandom);
    endtask

    // Starts one falling edge after the accepting edge and follows the run
    // until done. It checks latency, busy length, held output and result, and
    // returns at the falling edge inside the DONE cycle. If ignoreAt is not
    // negative, a start with a=0 is pulsed at that run cycle.
    task automatic waitDone(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin,
                            input int ignoreAt);
        logic [WIDTH-1:0] expSum;
        logic             expCout, expOvf;
        int               busyCycles = 0;
        int               doneAt = -1;
        modelAdd(a, b, cin, expSum, expCout, expOvf);
        for (int n = 0; n < 4 * WIDTH; n++) begin
            if (o_done) begin
                doneAt = n;
                break;
            end
            if (o_busy) busyCycles++;
            if (n == WIDTH / 2) checkOutput("sum_held", 32'(o_sum), 32'(heldSum));
            if (n == ignoreAt) begin
                i_start = 1'b1;
                i_a     = '0;
            end else begin
                i_start = 1'b0;
            end
            @(negedge i_clk);
        end
        i_start = 1'b0;
        checkOutput("latency", doneAt, WIDTH);
        checkOutput("busy_cycles", busyCycles, WIDTH);
        checkOutput("busy_in_done", 32'(o_busy), 0);
        checkOutput("sum", 32'(o_sum), 32'(expSum));
        checkOutput("cout", 32'(o_cout), 32'(expCout));
`ifdef SERIAL_ADDER_N_OVF_EN
        checkOutput("ovf", 32'(o_ovf), 32'(expOvf));
`endif
        heldSum  = expSum;
        heldCout = expCout;
        heldOvf  = expOvf;
    endtask

    // Leave DONE without a new start. The done pulse must end, and the
    // result must stay in place.
    task automatic settleIdle();
        @(negedge i_clk);
        checkOutput("done_pulse", 32'(o_done), 0);
        checkOutput("idle_busy", 32'(o_busy), 0);
        checkOutput("idle_sum", 32'(o_sum), 32'(heldSum));
    endtask

    // Run one operation from IDLE through completion and back to IDLE.
    task automatic singleOp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin);
        applyStimulus(a, b, cin);
        waitDone(a, b, cin, -1);
        settleIdle();
    endtask

    initial begin
        logic [WIDTH-1:0] ra, rb;
        logic             rc;
        bit               chained;

        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_a     = '0;
        i_b     = '0;
        i_cin   = 1'b0;

        // Reset state, and no activity while start stays low.
        repeat (3) @(negedge i_clk);
        checkOutput("rst_busy", 32'(o_busy), 0);
        checkOutput("rst_done", 32'(o_done), 0);
        checkOutput("rst_sum", 32'(o_sum), 0);
        checkOutput("rst_cout", 32'(o_cout), 0);
`ifdef SERIAL_ADDER_N_OVF_EN
        checkOutput("rst_ovf", 32'(o_ovf), 0);
`endif
        i_rst_n = 1'b1;
        i_a     = 8'hAA;
        i_b     = 8'h55;
        repeat (4) @(negedge i_clk);
        checkOutput("idle_no_start_busy", 32'(o_busy), 0);
        checkOutput("idle_no_start_done", 32'(o_done), 0);

        // Directed cases: basic add, carry chain, signed overflow.
        singleOp(8'h5A, 8'h33, 1'b0);
        singleOp(8'hFF, 8'h01, 1'b0);
        singleOp(8'h7F, 8'h01, 1'b0);

        // A start during the run is ignored. A start in the DONE cycle is
        // accepted at once.
        applyStimulus(8'h5A, 8'h33, 1'b0);
        waitDone(8'h5A, 8'h33, 1'b0, 3);
        applyStimulus(8'hFF, 8'hFF, 1'b1);
        waitDone(8'hFF, 8'hFF, 1'b1, -1);
        settleIdle();

        // Reset in the fourth cycle of a run aborts the operation.
        applyStimulus(8'h12, 8'h34, 1'b0);
        repeat (3) @(negedge i_clk);
        #2 i_rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(o_busy), 0);
        checkOutput("abort_done", 32'(o_done), 0);
        checkOutput("abort_sum", 32'(o_sum), 0);
        checkOutput("abort_cout", 32'(o_cout), 0);
`ifdef SERIAL_ADDER_N_OVF_EN
        checkOutput("abort_ovf", 32'(o_ovf), 0);
`endif
        heldSum  = '0;
        heldCout = 1'b0;
        heldOvf  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            checkOutput("abort_no_done", 32'(o_done), 0);
        end
        i_rst_n = 1'b1;
        @(negedge i_clk);
        checkOutput("post_abort_idle", 32'(o_busy), 0);
        singleOp(8'h10, 8'h20, 1'b0);

        // Random operations. Some are chained back-to-back from the DONE cycle.
        chained = 1'b0;
        for (int i = 0; i < 24; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rc = 1'($urandom);
            applyStimulus(ra, rb, rc);
            waitDone(ra, rb, rc, (($urandom_range(0, 3) == 0) ? int'($urandom_range(0, WIDTH - 2)) : -1));
            chained = ($urandom_range(0, 1) == 1);
            if (!chained) settleIdle();
        end
        if (chained) settleIdle();

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
